// File: rtl/memory_stage_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave).
// Single outstanding request, completed by a one-cycle mem_ready.
interface memory_stage_if;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/memory_stage.sv
// RV32I memory stage: loads/stores over a single-outstanding bus, load alignment
// and extension, writeback pulse, and fault pulse for misalignment / bus timeout.
module memory_stage #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  instruction,
  input  logic         write_enable,
  input  logic [4:0]   rd,
  input  logic [31:0]  rd_value,
  input  logic [31:0]  rs2_value,
  memory_stage_if.master bus,
  output logic         wb_write_enable,
  output logic [4:0]   wb_rd,
  output logic [31:0]  wb_rd_value,
  output logic         fault_valid,
  output logic [1:0]   fault_cause,
  output logic [31:0]  fault_addr
);

  typedef enum logic {IDLE, ACCESS} state_t;

  typedef struct packed {
    logic        is_load;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] addr;
  } pend_t;

  state_t      state;
  pend_t       pend;
  logic [31:0] tmo_cnt;
  logic        req_q, we_q;
  logic [31:0] addr_q, wdata_q;
  logic [3:0]  wstrb_q;

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [1:0]  off;
  logic        is_load, is_store, misal, bad_ld, bad_st, tmo_hit;
  logic [3:0]  wstrb_c;
  logic [31:0] wdata_c, load_val;

  wire unused_instr = &{1'b0, instruction[31:15], instruction[11:7]};

  assign opcode   = instruction[6:0];
  assign f3       = instruction[14:12];
  assign off      = rd_value[1:0];
  assign is_load  = (opcode == 7'b0000011);
  assign is_store = (opcode == 7'b0100011);
  // f3[1:0] encodes access size for both loads and stores
  assign misal    = (f3[1:0] == 2'b01 && off[0]) || (f3[1:0] == 2'b10 && off != 2'b00);
  assign bad_ld   = is_load  && (!(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) || misal);
  assign bad_st   = is_store && (!(f3 inside {3'b000, 3'b001, 3'b010}) || misal);
  assign tmo_hit  = (TIMEOUT_CYCLES != 0) && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign in_ready = (state == IDLE);

  always_comb begin
    wstrb_c = 4'b0000;
    wdata_c = 32'h0;
    case (f3[1:0])
      2'b00:   begin wstrb_c = 4'b0001 << off; wdata_c = {4{rs2_value[7:0]}};  end
      2'b01:   begin wstrb_c = 4'b0011 << off; wdata_c = {2{rs2_value[15:0]}}; end
      default: begin wstrb_c = 4'b1111;        wdata_c = rs2_value;            end
    endcase
  end

  always_comb begin
    logic [31:0] lane;
    lane = bus.mem_rdata >> {pend.addr[1:0], 3'b000};
    case (pend.f3)
      3'b000:  load_val = {{24{lane[7]}}, lane[7:0]};
      3'b001:  load_val = {{16{lane[15]}}, lane[15:0]};
      3'b100:  load_val = {24'h0, lane[7:0]};
      3'b101:  load_val = {16'h0, lane[15:0]};
      default: load_val = bus.mem_rdata;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      pend            <= '0;
      tmo_cnt         <= '0;
      req_q           <= 1'b0;
      we_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      wstrb_q         <= '0;
      wb_write_enable <= 1'b0;
      wb_rd           <= '0;
      wb_rd_value     <= '0;
      fault_valid     <= 1'b0;
      fault_cause     <= '0;
      fault_addr      <= '0;
    end else begin
      wb_write_enable <= 1'b0;
      fault_valid     <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          if (bad_ld || bad_st) begin
            fault_valid <= 1'b1;
            fault_cause <= bad_ld ? 2'b01 : 2'b10;
            fault_addr  <= rd_value;
          end else if (is_load || is_store) begin
            state   <= ACCESS;
            pend    <= '{is_load: is_load, f3: f3, rd: rd, addr: rd_value};
            tmo_cnt <= '0;
            req_q   <= 1'b1;
            we_q    <= is_store;
            addr_q  <= {rd_value[31:2], 2'b00};
            wstrb_q <= is_store ? wstrb_c : 4'b0000;
            wdata_q <= is_store ? wdata_c : 32'h0;
          end else begin
            wb_write_enable <= write_enable && (rd != 5'd0);
            wb_rd           <= rd;
            wb_rd_value     <= rd_value;
          end
        end
        ACCESS: begin
          // a ready arriving on the expiry cycle still completes the access
          if (bus.mem_ready) begin
            state <= IDLE;
            req_q <= 1'b0;
            if (pend.is_load) begin
              wb_write_enable <= (pend.rd != 5'd0);
              wb_rd           <= pend.rd;
              wb_rd_value     <= load_val;
            end
          end else if (tmo_hit) begin
            state       <= IDLE;
            req_q       <= 1'b0;
            fault_valid <= 1'b1;
            fault_cause <= 2'b11;
            fault_addr  <= pend.addr;
          end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.mem_req   = req_q;
  assign bus.mem_we    = we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_wstrb = wstrb_q;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage: pulses are scored against an expectation queue,
// bus fields and handshake levels are checked directly after each edge.
module tb_memory_stage;
  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] instruction;
  logic        write_enable;
  logic [4:0]  rd;
  logic [31:0] rd_value, rs2_value;
  logic        wb_write_enable;
  logic [4:0]  wb_rd;
  logic [31:0] wb_rd_value;
  logic        fault_valid;
  logic [1:0]  fault_cause;
  logic [31:0] fault_addr;

  memory_stage_if mif ();

  memory_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .write_enable(write_enable), .rd(rd),
    .rd_value(rd_value), .rs2_value(rs2_value), .bus(mif),
    .wb_write_enable(wb_write_enable), .wb_rd(wb_rd), .wb_rd_value(wb_rd_value),
    .fault_valid(fault_valid), .fault_cause(fault_cause), .fault_addr(fault_addr)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        is_fault;
    logic [4:0]  rd;
    logic [31:0] val;
    logic [1:0]  cause;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam logic [6:0] OP_LD = 7'b0000011, OP_ST = 7'b0100011, OP_ALU = 7'b0110011;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic we,
                       input logic [4:0] r, input logic [31:0] v, input logic [31:0] s);
    in_valid     = 1'b1;
    instruction  = {17'h0, f3, 5'h0, op};
    write_enable = we;
    rd           = r;
    rd_value     = v;
    rs2_value    = s;
  endtask

  function automatic exp_t wb_e(input logic [4:0] r, input logic [31:0] v);
    exp_t e;
    e.is_fault = 1'b0; e.rd = r; e.val = v; e.cause = 2'b00;
    return e;
  endfunction

  function automatic exp_t flt_e(input logic [1:0] c, input logic [31:0] a);
    exp_t e;
    e.is_fault = 1'b1; e.rd = 5'd0; e.val = a; e.cause = c;
    return e;
  endfunction

  // scoreboard: every pulse must match the oldest outstanding expectation
  always @(negedge clock) begin
    if (wb_write_enable || fault_valid) begin
      exp_t e;
      chk("pulse_overlap", 32'(wb_write_enable & fault_valid), 32'd0);
      n_cmp++;
      assert (exp_q.size() != 0) else begin
        n_bad++;
        $error("FAIL unexpected_pulse: observed wb=%0b fault=%0b expected none",
               wb_write_enable, fault_valid);
      end
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        if (e.is_fault) begin
          chk("fault_valid", 32'(fault_valid), 32'd1);
          chk("fault_cause", 32'(fault_cause), 32'(e.cause));
          chk("fault_addr",  fault_addr, e.val);
        end else begin
          chk("wb_we",    32'(wb_write_enable), 32'd1);
          chk("wb_rd",    32'(wb_rd), 32'(e.rd));
          chk("wb_value", wb_rd_value, e.val);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; in_valid = 1'b0; instruction = '0; write_enable = 1'b0;
    rd = '0; rd_value = '0; rs2_value = '0;
    mif.mem_ready = 1'b0; mif.mem_rdata = '0;
    tick(); tick();
    chk("rst_in_ready",  32'(in_ready), 32'd1);
    chk("rst_mem_req",   32'(mif.mem_req), 32'd0);
    chk("rst_mem_addr",  mif.mem_addr, 32'h0);
    chk("rst_mem_wstrb", 32'(mif.mem_wstrb), 32'h0);
    chk("rst_wb",        32'(wb_write_enable), 32'd0);
    chk("rst_wb_value",  wb_rd_value, 32'h0);
    chk("rst_fault",     32'(fault_valid), 32'd0);
    chk("rst_fault_addr", fault_addr, 32'h0);
    reset = 1'b0;
    tick();

    // pass-through, three back-to-back accepts
    drive(OP_ALU, 3'b000, 1'b1, 5'd5, 32'h1234, 32'h0);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(wb_e(5'd5, 32'h1234));
      tick();
      chk("pt_wb_pulse", 32'(wb_write_enable), 32'd1);
      chk("pt_in_ready", 32'(in_ready), 32'd1);
    end
    in_valid = 1'b0;
    tick();
    chk("pt_wb_end", 32'(wb_write_enable), 32'd0);

    // pass-through to x0 is suppressed
    drive(OP_ALU, 3'b000, 1'b1, 5'd0, 32'h55, 32'h0);
    tick(); in_valid = 1'b0;
    chk("pt_x0_wb", 32'(wb_write_enable), 32'd0);

    // LB / LBU / LH / LW, ready on the first ACCESS cycle
    begin
      logic [2:0]  f3s [4] = '{3'b000, 3'b100, 3'b001, 3'b010};
      logic [31:0] adr [4] = '{32'h103, 32'h103, 32'h102, 32'h100};
      logic [31:0] res [4] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h80FF_FF7F};
      for (int i = 0; i < 4; i++) begin
        drive(OP_LD, f3s[i], 1'b0, 5'(7 + i), adr[i], 32'h0);
        tick(); in_valid = 1'b0;
        chk("ld_req",   32'(mif.mem_req), 32'd1);
        chk("ld_addr",  mif.mem_addr, 32'h100);
        chk("ld_wstrb", 32'(mif.mem_wstrb), 32'h0);
        chk("ld_we",    32'(mif.mem_we), 32'd0);
        chk("ld_busy",  32'(in_ready), 32'd0);
        mif.mem_ready = 1'b1; mif.mem_rdata = 32'h80FF_FF7F;
        exp_q.push_back(wb_e(5'(7 + i), res[i]));
        tick(); mif.mem_ready = 1'b0;
        chk("ld_wb_pulse", 32'(wb_write_enable), 32'd1);
        chk("ld_req_drop", 32'(mif.mem_req), 32'd0);
        chk("ld_ready",    32'(in_ready), 32'd1);
      end
    end

    // SH at 0x202 with one wait cycle
    drive(OP_ST, 3'b001, 1'b0, 5'd3, 32'h202, 32'hAAAA_BEEF);
    tick(); in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("sh_req",   32'(mif.mem_req), 32'd1);
      chk("sh_addr",  mif.mem_addr, 32'h200);
      chk("sh_wstrb", 32'(mif.mem_wstrb), 32'b1100);
      chk("sh_wdata", mif.mem_wdata, 32'hBEEF_BEEF);
      chk("sh_we",    32'(mif.mem_we), 32'd1);
      chk("sh_busy",  32'(in_ready), 32'd0);
      if (i == 0) tick();
    end
    mif.mem_ready = 1'b1;
    tick(); mif.mem_ready = 1'b0;
    chk("sh_no_wb", 32'(wb_write_enable), 32'd0);
    chk("sh_done",  32'(in_ready), 32'd1);

    // SB at 0x001
    drive(OP_ST, 3'b000, 1'b0, 5'd0, 32'h001, 32'h1234_5678);
    tick(); in_valid = 1'b0;
    chk("sb_wstrb", 32'(mif.mem_wstrb), 32'b0010);
    chk("sb_wdata", mif.mem_wdata, 32'h7878_7878);
    mif.mem_ready = 1'b1;
    tick(); mif.mem_ready = 1'b0;

    // misaligned LW, misaligned SW, illegal load funct3
    begin
      logic [6:0]  ops [3] = '{OP_LD, OP_ST, OP_LD};
      logic [2:0]  f3s [3] = '{3'b010, 3'b010, 3'b011};
      logic [31:0] adr [3] = '{32'h301, 32'h302, 32'h308};
      logic [1:0]  cs  [3] = '{2'b01, 2'b10, 2'b01};
      for (int i = 0; i < 3; i++) begin
        drive(ops[i], f3s[i], 1'b0, 5'd4, adr[i], 32'h0);
        exp_q.push_back(flt_e(cs[i], adr[i]));
        tick(); in_valid = 1'b0;
        chk("mis_no_req", 32'(mif.mem_req), 32'd0);
        chk("mis_fault",  32'(fault_valid), 32'd1);
        chk("mis_ready",  32'(in_ready), 32'd1);
        tick();
        chk("mis_fault_end", 32'(fault_valid), 32'd0);
      end
    end

    // timeout: LW at 0x400, never ready
    drive(OP_LD, 3'b010, 1'b0, 5'd9, 32'h400, 32'h0);
    exp_q.push_back(flt_e(2'b11, 32'h400));
    tick(); in_valid = 1'b0;
    n = 0;
    while (mif.mem_req && n < 10) begin
      n++;
      tick();
    end
    chk("tmo_req_cycles", 32'(n), 32'd4);
    chk("tmo_fault",      32'(fault_valid), 32'd1);
    chk("tmo_ready",      32'(in_ready), 32'd1);
    tick();

    // ready on the 4th ACCESS cycle wins over expiry
    drive(OP_LD, 3'b010, 1'b0, 5'd9, 32'h400, 32'h0);
    tick(); in_valid = 1'b0;
    tick(); tick(); tick();
    chk("tmo_race_req", 32'(mif.mem_req), 32'd1);
    mif.mem_ready = 1'b1; mif.mem_rdata = 32'hCAFE_F00D;
    exp_q.push_back(wb_e(5'd9, 32'hCAFE_F00D));
    tick(); mif.mem_ready = 1'b0;
    chk("tmo_race_wb",    32'(wb_write_enable), 32'd1);
    chk("tmo_race_fault", 32'(fault_valid), 32'd0);

    // load to x0 still accesses memory, but writes nothing back
    drive(OP_LD, 3'b010, 1'b0, 5'd0, 32'h600, 32'h0);
    tick(); in_valid = 1'b0;
    chk("x0_ld_req", 32'(mif.mem_req), 32'd1);
    mif.mem_ready = 1'b1;
    tick(); mif.mem_ready = 1'b0;
    chk("x0_ld_wb", 32'(wb_write_enable), 32'd0);

    // reset in the second ACCESS cycle, then a late ready
    drive(OP_LD, 3'b010, 1'b0, 5'd10, 32'h500, 32'h0);
    tick(); in_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick(); reset = 1'b0;
    chk("rst_acc_req",   32'(mif.mem_req), 32'd0);
    chk("rst_acc_ready", 32'(in_ready), 32'd1);
    mif.mem_ready = 1'b1; mif.mem_rdata = 32'hDEAD_BEEF;
    tick(); mif.mem_ready = 1'b0;
    chk("late_rdy_wb",    32'(wb_write_enable), 32'd0);
    chk("late_rdy_fault", 32'(fault_valid), 32'd0);
    chk("late_rdy_req",   32'(mif.mem_req), 32'd0);
    chk("late_rdy_ready", 32'(in_ready), 32'd1);

    tick(); tick();
    chk("sb_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
